// File: rtl/cnt_multi_pkg.sv
// Shared constants and next-value rule for the multi-channel counter.
package cnt_multi_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    typedef struct packed {
        logic        term;
        logic [31:0] val;
    } step_t;

    // Limit compare happens before the increment, so cnt+1 never overflows.
    function automatic step_t step_next(
        input logic [31:0] cnt,
        input logic [31:0] lim,
        input logic        dir,
        input logic        mode
    );
        step_t r;
        r.term = 1'b0;
        r.val  = cnt;
        if (dir == DIR_UP) begin
            if (cnt < lim) begin
                r.val = cnt + 32'd1;
            end else begin
                r.term = 1'b1;
                r.val  = (mode == MODE_SAT) ? lim : 32'd0;
            end
        end else begin
            if (cnt != 32'd0) begin
                r.val = cnt - 32'd1;
            end else begin
                r.term = 1'b1;
                r.val  = (mode == MODE_SAT) ? 32'd0 : lim;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_multi_ch.sv
// One counter channel: CNT and TC registers with CLR > LD > CE priority.
module cnt_multi_ch
    import cnt_multi_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             CE,
    input  logic             LD,
    input  logic [WIDTH-1:0] LD_VAL,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             DIR,
    input  logic             MODE,
    output logic [WIDTH-1:0] CNT,
    output logic             TC
);

    step_t            st;
    logic [WIDTH-1:0] cnt_nx;
    logic             tc_nx;

    always_comb begin
        st     = step_next(32'(CNT), 32'(LIMIT), DIR, MODE);
        cnt_nx = CNT;
        tc_nx  = 1'b0;
        if (CLR) begin
            cnt_nx = '0;
        end else if (LD) begin
            cnt_nx = (LD_VAL > LIMIT) ? LIMIT : LD_VAL;
        end else if (CE) begin
            cnt_nx = st.val[WIDTH-1:0];
            tc_nx  = st.term;
        end
    end

    generate
        if (WIDTH < 32) begin : g_hi
            logic hi_unused;
            assign hi_unused = ^st.val[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CNT <= '0;
            TC  <= 1'b0;
        end else begin
            CNT <= cnt_nx;
            TC  <= tc_nx;
        end
    end

endmodule

// File: rtl/cnt_multi.sv
// NCH-channel counter with shared limit register.
// Optional snapshot bank enabled by CNT_MULTI_SNAP_EN.
module cnt_multi
    import cnt_multi_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               NCH       = 4,
    parameter logic [WIDTH-1:0] DEF_LIMIT = '1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH-1:0]       CLR,
    input  logic [NCH-1:0]       CE,
    input  logic [NCH-1:0]       LD,
    input  logic [NCH*WIDTH-1:0] LD_VAL,
    input  logic                 DIR,
    input  logic                 MODE,
    input  logic                 LIM_WE,
    input  logic [WIDTH-1:0]     LIM_VAL,
    output logic [NCH*WIDTH-1:0] CNT,
    output logic [NCH-1:0]       TC
`ifdef CNT_MULTI_SNAP_EN
    ,
    input  logic                 SNAP,
    output logic [NCH*WIDTH-1:0] SNAP_CNT
`endif
);

    logic [WIDTH-1:0] limit;

    // Writes land at the edge; steps in that cycle see the old limit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            limit <= DEF_LIMIT;
        end else if (LIM_WE) begin
            limit <= LIM_VAL;
        end
    end

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_ch
            cnt_multi_ch #(
                .WIDTH(WIDTH)
            ) u_ch (
                .CLK   (CLK),
                .RST   (RST),
                .CLR   (CLR[i]),
                .CE    (CE[i]),
                .LD    (LD[i]),
                .LD_VAL(LD_VAL[i*WIDTH +: WIDTH]),
                .LIMIT (limit),
                .DIR   (DIR),
                .MODE  (MODE),
                .CNT   (CNT[i*WIDTH +: WIDTH]),
                .TC    (TC[i])
            );
        end
    endgenerate

`ifdef CNT_MULTI_SNAP_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            SNAP_CNT <= '0;
        end else if (SNAP) begin
            SNAP_CNT <= CNT;
        end
    end
`endif

endmodule
